// File: rtl/src_bus_pkg.sv
// Shared datapath-bus source definitions: source count, index width, named source
// indices and the one-hot to index encoding used by the bus-select encoder.
package src_bus_pkg;

  localparam int SRC_NUM   = 32;
  localparam int SRC_IDX_W = 5;

  typedef logic [SRC_NUM-1:0]   src_vec_t;
  typedef logic [SRC_IDX_W-1:0] src_idx_t;

  // Bus source indices shared by the control unit, the encoder and the bus mux
  localparam src_idx_t SRC_R0     = 5'd0;
  localparam src_idx_t SRC_R1     = 5'd1;
  localparam src_idx_t SRC_R2     = 5'd2;
  localparam src_idx_t SRC_R3     = 5'd3;
  localparam src_idx_t SRC_R4     = 5'd4;
  localparam src_idx_t SRC_R5     = 5'd5;
  localparam src_idx_t SRC_R6     = 5'd6;
  localparam src_idx_t SRC_R7     = 5'd7;
  localparam src_idx_t SRC_R8     = 5'd8;
  localparam src_idx_t SRC_R9     = 5'd9;
  localparam src_idx_t SRC_R10    = 5'd10;
  localparam src_idx_t SRC_R11    = 5'd11;
  localparam src_idx_t SRC_R12    = 5'd12;
  localparam src_idx_t SRC_R13    = 5'd13;
  localparam src_idx_t SRC_R14    = 5'd14;
  localparam src_idx_t SRC_R15    = 5'd15;
  localparam src_idx_t SRC_HI     = 5'd16;
  localparam src_idx_t SRC_LO     = 5'd17;
  localparam src_idx_t SRC_ZHIGH  = 5'd18;
  localparam src_idx_t SRC_ZLOW   = 5'd19;
  localparam src_idx_t SRC_PC     = 5'd20;
  localparam src_idx_t SRC_MDR    = 5'd21;
  localparam src_idx_t SRC_INPORT = 5'd22;
  localparam src_idx_t SRC_C      = 5'd23;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // OR of the indices of all set bits; exact for a one-hot vector, 0 for all-zero
  function automatic src_idx_t onehot_to_idx(input src_vec_t vec);
    src_idx_t idx;
    idx = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (vec[i]) idx = idx | src_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: lowest set request at or above start, wrapping
// past the top index, built as a masked priority search over a doubled vector.
module rr_priority_pick
  import src_bus_pkg::*;
(
  input  logic [SRC_NUM-1:0]   req,
  input  logic [SRC_IDX_W-1:0] start,
  output logic [SRC_NUM-1:0]   win,
  output logic                 any
);

  logic [2*SRC_NUM-1:0] w_dbl;
  logic [2*SRC_NUM-1:0] w_mask;
  logic [2*SRC_NUM-1:0] w_masked;
  logic [2*SRC_NUM-1:0] w_lowest;

  // Lower copy keeps only indices >= start; upper copy stands for the wrapped search
  assign w_dbl    = {req, req};
  assign w_mask   = ~(({{(2*SRC_NUM-1){1'b0}}, 1'b1} << start) - {{(2*SRC_NUM-1){1'b0}}, 1'b1});
  assign w_masked = w_dbl & w_mask;
  assign w_lowest = w_masked & (~w_masked + {{(2*SRC_NUM-1){1'b0}}, 1'b1});

  assign win = w_lowest[SRC_NUM-1:0] | w_lowest[2*SRC_NUM-1:SRC_NUM];
  assign any = |req;

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus-drive arbiter: registered one-hot-or-zero grant with a hold
// limit that forces rotation when other sources wait, unless lock is held.
module bus_grant_arbiter
  import src_bus_pkg::*;
#(
  parameter int NUM_SRC  = SRC_NUM,
  parameter int MAX_HOLD = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] req,
  input  logic               lock,
  output logic [NUM_SRC-1:0] grant,
  output logic               grant_vld,
  output logic [3:0]         hold_cnt
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);
  localparam logic [3:0] HOLD_SAT   = 4'd15;

  arb_state_t r_state;
  src_vec_t   r_grant;
  logic       r_grant_vld;
  logic [3:0] r_hold_cnt;
  src_idx_t   r_rr_ptr;

  src_vec_t   w_cand;
  src_vec_t   w_win;
  logic       w_any;
  logic       w_holder_req;
  logic       w_timeout;
  src_idx_t   w_win_idx;

  // The current holder never competes against itself, so a forced rotation or a
  // release always lands on a different source
  assign w_cand       = (r_state == ARB_GRANT) ? (req & ~r_grant) : req;
  assign w_holder_req = |(req & r_grant);
  assign w_timeout    = (r_hold_cnt == HOLD_LIMIT) && !lock;

  rr_priority_pick u_pick (
    .req   (w_cand),
    .start (r_rr_ptr),
    .win   (w_win),
    .any   (w_any)
  );

  assign w_win_idx = onehot_to_idx(w_win);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_grant_vld <= 1'b0;
      r_hold_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state     <= ARB_GRANT;
            r_grant     <= w_win;
            r_grant_vld <= 1'b1;
            r_hold_cnt  <= '0;
            r_rr_ptr    <= w_win_idx + 5'd1;
          end
        end
        ARB_GRANT: begin
          if (w_holder_req && !(w_timeout && w_any)) begin
            if (r_hold_cnt != HOLD_SAT) r_hold_cnt <= r_hold_cnt + 4'd1;
          end else if (w_any) begin
            r_grant     <= w_win;
            r_grant_vld <= 1'b1;
            r_hold_cnt  <= '0;
            r_rr_ptr    <= w_win_idx + 5'd1;
          end else begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_hold_cnt  <= '0;
          end
        end
        default: begin
          r_state     <= ARB_IDLE;
          r_grant     <= '0;
          r_grant_vld <= 1'b0;
          r_hold_cnt  <= '0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_vld = r_grant_vld;
  assign hold_cnt  = r_hold_cnt;

  a_grant_onehot0 : assert property (@(posedge clock) $onehot0(r_grant));
  a_vld_matches   : assert property (@(posedge clock) r_grant_vld == (|r_grant));

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Bench for bus_grant_arbiter: directed vector table, corner sequences and a
// randomized run against a cycle-level reference model of the arbitration rules.
module tb_bus_grant_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] req   = '0;
  logic        lock  = 1'b0;
  logic [31:0] grant;
  logic        grant_vld;
  logic [3:0]  hold_cnt;

  int checks   = 0;
  int failures = 0;

  int m_holder = -1;
  int m_rr     = 0;
  int m_hold   = 0;

  bus_grant_arbiter #(.NUM_SRC(32), .MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .clear     (clear),
    .req       (req),
    .lock      (lock),
    .grant     (grant),
    .grant_vld (grant_vld),
    .hold_cnt  (hold_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic [31:0] rq;
    logic        lk;
    logic [31:0] g;
    logic        v;
    logic [3:0]  h;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [31:0] rq, input int start);
    for (int i = 0; i < 32; i++) begin
      if (rq[(start + i) % 32]) return (start + i) % 32;
    end
    return -1;
  endfunction

  task automatic model_step(input logic c, input logic [31:0] rq, input logic lk);
    logic [31:0] others;
    if (c) begin
      m_holder = -1; m_rr = 0; m_hold = 0;
    end else if (m_holder < 0) begin
      if (rq != 0) begin
        m_holder = pick(rq, m_rr); m_rr = (m_holder + 1) % 32; m_hold = 0;
      end
    end else begin
      others = rq & ~(32'd1 << m_holder);
      if (rq[m_holder] && !(m_hold == MAX_HOLD - 1 && !lk && others != 0)) begin
        m_hold = (m_hold < 15) ? m_hold + 1 : 15;
      end else if (others != 0) begin
        m_holder = pick(others, m_rr); m_rr = (m_holder + 1) % 32; m_hold = 0;
      end else begin
        m_holder = -1; m_hold = 0;
      end
    end
  endtask

  // One clock: drive at the falling edge, let the DUT and model advance, compare
  task automatic step(input logic c, input logic [31:0] rq, input logic lk);
    logic [31:0] exp_g;
    int enc;
    clear = c; req = rq; lock = lk;
    @(posedge clock);
    model_step(c, rq, lk);
    @(negedge clock);
    exp_g = (m_holder < 0) ? 32'd0 : (32'd1 << m_holder);
    chk("model_grant", grant, exp_g);
    chk("model_vld", 32'(grant_vld), 32'(m_holder >= 0));
    chk("model_hold", 32'(hold_cnt), 32'(m_hold));
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    enc = 0;
    for (int i = 0; i < 32; i++) if (grant[i]) enc = enc | i;
    chk("enc_idx", 32'(enc), 32'((m_holder < 0) ? 0 : m_holder));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1, 4'd0};
    tbl[2]  = '{1'b0, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1, 4'd1};
    tbl[3]  = '{1'b0, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1, 4'd2};
    tbl[4]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 4'd0};
    tbl[5]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 4'd0};
    tbl[6]  = '{1'b0, 32'h8000_0001, 1'b0, 32'h0000_0001, 1'b1, 4'd0};
    tbl[7]  = '{1'b0, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 4'd0};
    tbl[8]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 4'd0};
    tbl[9]  = '{1'b0, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 4'd0};
    tbl[10] = '{1'b0, 32'h0000_0006, 1'b0, 32'h0000_0002, 1'b1, 4'd0};
    tbl[11] = '{1'b0, 32'h0000_0006, 1'b0, 32'h0000_0002, 1'b1, 4'd1};
    tbl[12] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 4'd0};
    tbl[13] = '{1'b0, 32'h8000_0003, 1'b0, 32'h8000_0000, 1'b1, 4'd0};
    tbl[14] = '{1'b0, 32'h8000_0003, 1'b0, 32'h8000_0000, 1'b1, 4'd1};
    tbl[15] = '{1'b1, 32'h8000_0003, 1'b0, 32'h0000_0000, 1'b0, 4'd0};
    tbl[16] = '{1'b0, 32'h8000_0003, 1'b0, 32'h0000_0001, 1'b1, 4'd0};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].clr, tbl[i].rq, tbl[i].lk);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_vld", i), 32'(grant_vld), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_hold", i), 32'(hold_cnt), 32'(tbl[i].h));
    end

    // Forced rotation: bit4 holds for exactly MAX_HOLD cycles, then bit9 takes over
    step(1'b1, 32'h0, 1'b0);
    step(1'b0, 32'h0000_0010, 1'b0);
    chk("rot_first", grant, 32'h0000_0010);
    for (int i = 1; i < MAX_HOLD; i++) begin
      step(1'b0, 32'h0000_0210, 1'b0);
      chk("rot_hold_grant", grant, 32'h0000_0010);
      chk("rot_hold_cnt", 32'(hold_cnt), 32'(i));
    end
    step(1'b0, 32'h0000_0210, 1'b0);
    chk("rot_switch_grant", grant, 32'h0000_0200);
    chk("rot_switch_hold", 32'(hold_cnt), 32'd0);

    // Lock: bit4 keeps the bus well past the limit, hold_cnt saturates at 15
    step(1'b1, 32'h0, 1'b0);
    step(1'b0, 32'h0000_0010, 1'b1);
    for (int i = 1; i < 20; i++) begin
      step(1'b0, 32'h0000_0210, 1'b1);
      chk("lock_grant", grant, 32'h0000_0010);
      chk("lock_hold", 32'(hold_cnt), 32'((i > 15) ? 15 : i));
    end

    // Clear mid-grant releases the bus on the very next edge
    step(1'b1, 32'h0000_0210, 1'b1);
    chk("clr_grant", grant, 32'h0);
    chk("clr_vld", 32'(grant_vld), 32'd0);
    chk("clr_hold", 32'(hold_cnt), 32'd0);

    // Sole requester at the limit keeps the bus and keeps counting
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0000_0010, 1'b0);
      chk("solo_grant", grant, 32'h0000_0010);
    end
    chk("solo_hold", 32'(hold_cnt), 32'd11);

    // Randomized run with persistent, slowly changing requests
    begin
      logic [31:0] r_req;
      logic        r_lock;
      logic        r_clr;
      r_req  = 32'h0000_0000;
      r_lock = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 3) == 0) r_req[$urandom_range(0, 31)] ^= 1'b1;
        if ($urandom_range(0, 3) == 0) r_req[$urandom_range(0, 7)]  ^= 1'b1;
        if ($urandom_range(0, 63) == 0) r_req = 32'h0;
        if ($urandom_range(0, 9) == 0) r_lock = ~r_lock;
        r_clr = ($urandom_range(0, 99) == 0);
        step(r_clr, r_req, r_lock);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
